exe_stage_mdu: RTL and testbench
================================

// Module: exe_stage_mdu
// PURPOSE
//  Next-generation EXE stage for the pipelined CPU.
//  Keeps the single-cycle ALU path: operand muxing for shift amount and immediate.
//  Adds a WIDTH-parametrised iterative multiply/divide unit (MDU) with HI/LO registers.
//  Raises a stall to the hazard unit while a MULT/DIV is in progress.
// PARAMETERS
//  WIDTH   32  datapath width; operands, ALU result, HI, LO
//  SA_LSB  5   LSB of shift-amount field in eimm (field width = clog2(WIDTH))
// PORTS
//  clk     in   1      clock; all state updates on rising edge
//  rst     in   1      reset: asynchronous, active-high
//  ev      in   1      valid instruction present in EXE
//  ea      in   WIDTH  register operand a
//  eb      in   WIDTH  register operand b
//  eimm    in   WIDTH  extended immediate
//  ealuc   in   4      ALU op
//  ealuimm in   1      1: ALU b = eimm, else eb
//  eshift  in   1      1: ALU a = zero-extended shamt field, else ea
//  emdop   in   3      000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MFHI, 110 MFLO
//  ealu    out  WIDTH  EXE result
//  z       out  1      ealu == 0
//  stall   out  1      freeze IF/ID/EXE
//  hi      out  WIDTH  HI register
//  lo      out  WIDTH  LO register
// BEHAVIOUR
//  ALU (combinational, 0 latency), ealuc values:
//   0 ADD, 1 SUB: wrap mod 2^WIDTH, no overflow trap.
//   2 AND, 3 OR, 4 XOR.
//   5 LUI: b << (WIDTH/2).
//   6 SLL, 7 SRL, 8 SRA: shift b by a[clog2(WIDTH)-1:0].
//   9 SLT (signed), 10 SLTU: result is 0 or 1.
//   11..15: result 0.
//  ealu mux: emdop=101 -> hi; emdop=110 -> lo; otherwise ALU result.
//  FSM states: IDLE, MUL, DIV, DONE. Reset -> IDLE; hi=lo=0; counter=0; stall=0.
//  IDLE, ev=1, emdop in {001..100} (cycle 0):
//   - Load magnitudes: abs() for signed ops, raw for unsigned.
//   - Record result signs. counter=WIDTH.
//   - Next state MUL or DIV. stall=1 combinationally in this cycle.
//  MUL: one shift-add step per cycle; counter--.
//  DIV: one restoring step per cycle; counter--.
//  Last step (counter==1):
//   - Write sign-corrected result to hi/lo; next state DONE.
//   - MULT: {hi,lo} = 2*WIDTH-bit product.
//   - DIV: lo = quotient (truncated toward 0); hi = remainder (sign of dividend).
//  stall=1 in every MUL/DIV cycle: total WIDTH+1 stalled cycles, results visible from DONE.
//  DONE: stall=0 so the instruction retires; no restart despite emdop still set; -> IDLE.
//  Divide by zero (eb==0 at start): no iterations.
//   - Next state DONE; hi=ea, lo=all ones. Exactly 1 stalled cycle.
//  Signed DIV of MIN by -1: lo=MIN, hi=0 (wraps, no trap).
//  ev=0 or emdop in {000,101,110,111} in IDLE: no MDU activity, stall=0.
//  emdop changes while busy: ignored; operands latched at start.
//  rst asserted mid-operation: immediate IDLE, hi=lo=0, stall=0; result discarded.
//  HI/LO written only at completion; MFHI/MFLO read register value combinationally.
// TESTING
//  1. ADD 0x7FFFFFFF+1 -> ealu=0x80000000, z=0; SUB 5-5 -> ealu=0, z=1.
//  2. eshift=1, eimm[9:5]=4, eb=0xF0000001, SRA -> ealu=0xFF000000; SRL -> 0x0F000000.
//  3. MULT ea=-3, eb=5 -> stall high 33 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFF1; MFLO ealu=0xFFFFFFF1.
//  4. DIVU 100/7 -> lo=14, hi=2.
//     DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//     DIV 0x80000000/-1 -> lo=0x80000000, hi=0.
//  5. DIV ea=9, eb=0 -> stall 1 cycle; hi=9, lo=0xFFFFFFFF.
//     Back-to-back MULTU 0xFFFFFFFF^2 -> hi=0xFFFFFFFE, lo=1.
//  6. rst pulse at cycle 10 of a MULT -> stall=0 same cycle, hi=lo=0.
//     Next MULT 2*3 completes normally: lo=6.

Source files
------------

// File: rtl/exe_stage_mdu.sv
// EXE stage: single-cycle ALU with shift/immediate operand muxing, plus an
// iterative shift-add multiplier / restoring divider writing the HI/LO registers.
module exe_stage_mdu #(
    parameter int WIDTH  = 32,
    parameter int SA_LSB = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ev,
    input  logic [WIDTH-1:0] ea,
    input  logic [WIDTH-1:0] eb,
    input  logic [WIDTH-1:0] eimm,
    input  logic [3:0]       ealuc,
    input  logic             ealuimm,
    input  logic             eshift,
    input  logic [2:0]       emdop,
    output logic [WIDTH-1:0] ealu,
    output logic             z,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d, mq_q, mq_d, mcand_q, mcand_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             neg_q, neg_d, rneg_q, rneg_d;
    logic             busy_s;

    logic [WIDTH-1:0] alu_a_s, alu_b_s, alu_res_s;
    logic [SHW-1:0]   sh_s;

    assign alu_a_s = eshift ? {{(WIDTH-SHW){1'b0}}, eimm[SA_LSB +: SHW]} : ea;
    assign alu_b_s = ealuimm ? eimm : eb;
    assign sh_s    = alu_a_s[SHW-1:0];

    // Single-cycle ALU
    always_comb begin
        alu_res_s = {WIDTH{1'b0}};
        case (ealuc)
            4'd0:    alu_res_s = alu_a_s + alu_b_s;
            4'd1:    alu_res_s = alu_a_s - alu_b_s;
            4'd2:    alu_res_s = alu_a_s & alu_b_s;
            4'd3:    alu_res_s = alu_a_s | alu_b_s;
            4'd4:    alu_res_s = alu_a_s ^ alu_b_s;
            4'd5:    alu_res_s = alu_b_s << (WIDTH / 2);
            4'd6:    alu_res_s = alu_b_s << sh_s;
            4'd7:    alu_res_s = alu_b_s >> sh_s;
            4'd8:    alu_res_s = $signed(alu_b_s) >>> sh_s;
            4'd9:    alu_res_s = {{(WIDTH-1){1'b0}}, ($signed(alu_a_s) < $signed(alu_b_s))};
            4'd10:   alu_res_s = {{(WIDTH-1){1'b0}}, (alu_a_s < alu_b_s)};
            default: alu_res_s = {WIDTH{1'b0}};
        endcase
    end

    // Result mux: MFHI/MFLO read the registers, everything else takes the ALU
    always_comb begin
        case (emdop)
            3'b101:  ealu = hi_q;
            3'b110:  ealu = lo_q;
            default: ealu = alu_res_s;
        endcase
    end

    assign z  = (ealu == {WIDTH{1'b0}});
    assign hi = hi_q;
    assign lo = lo_q;

    logic             start_s, signed_s, is_div_s;
    logic [WIDTH-1:0] a_mag_s, b_mag_s;

    assign start_s  = ev && (emdop >= 3'b001) && (emdop <= 3'b100);
    assign signed_s = (emdop == 3'b001) || (emdop == 3'b011);
    assign is_div_s = (emdop == 3'b011) || (emdop == 3'b100);
    assign a_mag_s  = (signed_s && ea[WIDTH-1]) ? (~ea + {{(WIDTH-1){1'b0}}, 1'b1}) : ea;
    assign b_mag_s  = (signed_s && eb[WIDTH-1]) ? (~eb + {{(WIDTH-1){1'b0}}, 1'b1}) : eb;

    // Multiply step: acc holds the running upper half, mq the shrinking multiplier
    logic [WIDTH:0]     mul_sum_s;
    logic [WIDTH-1:0]   mul_hi_s, mul_lo_s;
    logic [2*WIDTH-1:0] prod_s, prod_fix_s;

    assign mul_sum_s  = {1'b0, acc_q} + {1'b0, (mq_q[0] ? mcand_q : {WIDTH{1'b0}})};
    assign mul_hi_s   = mul_sum_s[WIDTH:1];
    assign mul_lo_s   = {mul_sum_s[0], mq_q[WIDTH-1:1]};
    assign prod_s     = {mul_hi_s, mul_lo_s};
    assign prod_fix_s = neg_q ? (~prod_s + {{(2*WIDTH-1){1'b0}}, 1'b1}) : prod_s;

    // Restoring divide step: acc is the partial remainder, mq shifts dividend out / quotient in
    logic [WIDTH:0]   div_sh_s, div_diff_s;
    logic             div_ok_s;
    logic [WIDTH-1:0] div_rem_s, div_quo_s;

    assign div_sh_s   = {acc_q, mq_q[WIDTH-1]};
    assign div_diff_s = div_sh_s - {1'b0, mcand_q};
    assign div_ok_s   = ~div_diff_s[WIDTH];
    assign div_rem_s  = div_ok_s ? div_diff_s[WIDTH-1:0] : div_sh_s[WIDTH-1:0];
    assign div_quo_s  = {mq_q[WIDTH-2:0], div_ok_s};

    // MDU sequencing and HI/LO next-state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        mq_d    = mq_q;
        mcand_d = mcand_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        busy_s  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_s) begin
                    busy_s = 1'b1;
                    if (is_div_s && (eb == {WIDTH{1'b0}})) begin
                        hi_d    = ea;
                        lo_d    = {WIDTH{1'b1}};
                        state_d = S_DONE;
                    end else begin
                        mcand_d = b_mag_s;
                        mq_d    = a_mag_s;
                        acc_d   = {WIDTH{1'b0}};
                        cnt_d   = CW'(WIDTH);
                        neg_d   = signed_s && (ea[WIDTH-1] ^ eb[WIDTH-1]);
                        rneg_d  = signed_s && ea[WIDTH-1];
                        state_d = is_div_s ? S_DIV : S_MUL;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MUL: begin
                busy_s = 1'b1;
                cnt_d  = cnt_q - CW'(1);
                acc_d  = mul_hi_s;
                mq_d   = mul_lo_s;
                if (cnt_q == CW'(1)) begin
                    {hi_d, lo_d} = prod_fix_s;
                    state_d      = S_DONE;
                end else begin
                    state_d = S_MUL;
                end
            end
            S_DIV: begin
                busy_s = 1'b1;
                cnt_d  = cnt_q - CW'(1);
                acc_d  = div_rem_s;
                mq_d   = div_quo_s;
                if (cnt_q == CW'(1)) begin
                    lo_d    = neg_q  ? (~div_quo_s + {{(WIDTH-1){1'b0}}, 1'b1}) : div_quo_s;
                    hi_d    = rneg_q ? (~div_rem_s + {{(WIDTH-1){1'b0}}, 1'b1}) : div_rem_s;
                    state_d = S_DONE;
                end else begin
                    state_d = S_DIV;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Stall is masked during reset so a held MDU opcode cannot freeze the pipe
    assign stall = busy_s && !rst;

    // MDU state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= {CW{1'b0}};
            acc_q   <= {WIDTH{1'b0}};
            mq_q    <= {WIDTH{1'b0}};
            mcand_q <= {WIDTH{1'b0}};
            hi_q    <= {WIDTH{1'b0}};
            lo_q    <= {WIDTH{1'b0}};
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            mq_q    <= mq_d;
            mcand_q <= mcand_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
        end
    end
endmodule

// File: tb/tb_exe_stage_mdu.sv
// Directed-vector bench for exe_stage_mdu: ALU ops, MDU results, stall length, reset abort.
module tb_exe_stage_mdu;
    logic        clk = 1'b0;
    logic        rst;
    logic        ev;
    logic [31:0] ea, eb, eimm;
    logic [3:0]  ealuc;
    logic        ealuimm, eshift;
    logic [2:0]  emdop;
    logic [31:0] ealu, hi, lo;
    logic        z, stall;

    int total = 0;
    int bad   = 0;

    localparam logic [2:0] MD_NONE  = 3'b000;
    localparam logic [2:0] MD_MULT  = 3'b001;
    localparam logic [2:0] MD_MULTU = 3'b010;
    localparam logic [2:0] MD_DIV   = 3'b011;
    localparam logic [2:0] MD_DIVU  = 3'b100;
    localparam logic [2:0] MD_MFHI  = 3'b101;
    localparam logic [2:0] MD_MFLO  = 3'b110;

    exe_stage_mdu #(.WIDTH(32), .SA_LSB(5)) dut (
        .clk(clk), .rst(rst), .ev(ev), .ea(ea), .eb(eb), .eimm(eimm),
        .ealuc(ealuc), .ealuimm(ealuimm), .eshift(eshift), .emdop(emdop),
        .ealu(ealu), .z(z), .stall(stall), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm, input logic aimm, input logic sh);
        ev = 1'b1; emdop = MD_NONE; ealuc = op; ea = a; eb = b;
        eimm = imm; ealuimm = aimm; eshift = sh;
        #1;
    endtask

    // Issue an MDU op, count stalled cycles; abort_at>0 returns early while still busy
    task automatic run_mdu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input int abort_at, output int cnt);
        ev = 1'b1; emdop = op; ea = a; eb = b; ealuc = 4'd0; ealuimm = 1'b0; eshift = 1'b0;
        #1;
        cnt = 0;
        while (stall && cnt < 200) begin
            cnt++;
            if (abort_at > 0 && cnt == abort_at) return;
            step();
            if (cnt == 2) begin
                ea = ~a;
                eb = ~b;
            end
        end
        ev = 1'b0; emdop = MD_NONE;
        step();
    endtask

    int n;

    initial begin
        rst = 1'b1; ev = 1'b0; ea = 32'd0; eb = 32'd0; eimm = 32'd0;
        ealuc = 4'd0; ealuimm = 1'b0; eshift = 1'b0; emdop = MD_NONE;
        step(); step();
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        rst = 1'b0;
        step();

        alu(4'd0, 32'h7FFFFFFF, 32'h1, 32'h0, 1'b0, 1'b0);
        chk("add", ealu, 32'h80000000);
        chk("add_z", {31'd0, z}, 32'd0);
        alu(4'd1, 32'd5, 32'd5, 32'h0, 1'b0, 1'b0);
        chk("sub", ealu, 32'h0);
        chk("sub_z", {31'd0, z}, 32'd1);
        chk("alu_nostall", {31'd0, stall}, 32'd0);
        alu(4'd8, 32'hDEADBEEF, 32'hF0000001, 32'h00000080, 1'b0, 1'b1);
        chk("sra", ealu, 32'hFF000000);
        alu(4'd7, 32'hDEADBEEF, 32'hF0000001, 32'h00000080, 1'b0, 1'b1);
        chk("srl", ealu, 32'h0F000000);
        alu(4'd6, 32'h00000003, 32'h00000011, 32'h0, 1'b0, 1'b0);
        chk("sll", ealu, 32'h00000088);
        alu(4'd2, 32'hFF00FF00, 32'h0, 32'h0F0F0F0F, 1'b1, 1'b0);
        chk("and_imm", ealu, 32'h0F000F00);
        alu(4'd3, 32'hF0000000, 32'h0000000F, 32'h0, 1'b0, 1'b0);
        chk("or", ealu, 32'hF000000F);
        alu(4'd4, 32'hFFFF0000, 32'h0FF00FF0, 32'h0, 1'b0, 1'b0);
        chk("xor", ealu, 32'hF00F0FF0);
        alu(4'd5, 32'h0, 32'h0, 32'h00001234, 1'b1, 1'b0);
        chk("lui", ealu, 32'h12340000);
        alu(4'd9, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b0, 1'b0);
        chk("slt", ealu, 32'h1);
        alu(4'd10, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b0, 1'b0);
        chk("sltu", ealu, 32'h0);
        alu(4'd12, 32'h5, 32'h6, 32'h0, 1'b0, 1'b0);
        chk("op12", ealu, 32'h0);
        emdop = 3'b111;
        #1;
        chk("op7_nostall", {31'd0, stall}, 32'd0);
        ev = 1'b0; emdop = MD_NONE;
        step();

        run_mdu(MD_MULT, 32'hFFFFFFFD, 32'd5, 0, n);
        chk("mult_stall", n, 32'd33);
        chk("mult_hi", hi, 32'hFFFFFFFF);
        chk("mult_lo", lo, 32'hFFFFFFF1);
        ev = 1'b1; emdop = MD_MFLO;
        #1;
        chk("mflo", ealu, 32'hFFFFFFF1);
        emdop = MD_MFHI;
        #1;
        chk("mfhi", ealu, 32'hFFFFFFFF);
        step();

        run_mdu(MD_DIVU, 32'd100, 32'd7, 0, n);
        chk("divu_stall", n, 32'd33);
        chk("divu_lo", lo, 32'd14);
        chk("divu_hi", hi, 32'd2);
        run_mdu(MD_DIV, 32'hFFFFFFF9, 32'd2, 0, n);
        chk("div_lo", lo, 32'hFFFFFFFD);
        chk("div_hi", hi, 32'hFFFFFFFF);
        run_mdu(MD_DIV, 32'h80000000, 32'hFFFFFFFF, 0, n);
        chk("divmin_lo", lo, 32'h80000000);
        chk("divmin_hi", hi, 32'h0);
        run_mdu(MD_DIV, 32'd9, 32'd0, 0, n);
        chk("div0_stall", n, 32'd1);
        chk("div0_hi", hi, 32'd9);
        chk("div0_lo", lo, 32'hFFFFFFFF);
        run_mdu(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, n);
        chk("multu_hi", hi, 32'hFFFFFFFE);
        chk("multu_lo", lo, 32'h1);

        run_mdu(MD_MULT, 32'hFFFFFFFD, 32'd5, 10, n);
        chk("abort_busy", {31'd0, stall}, 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_stall", {31'd0, stall}, 32'd0);
        chk("abort_hi", hi, 32'h0);
        chk("abort_lo", lo, 32'h0);
        step();
        rst = 1'b0; ev = 1'b0; emdop = MD_NONE;
        step();
        run_mdu(MD_MULT, 32'd2, 32'd3, 0, n);
        chk("mult23_stall", n, 32'd33);
        chk("mult23_lo", lo, 32'd6);
        chk("mult23_hi", hi, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
